// File: rtl/wb_snoop_coherence_arbiter_if.sv
// Bus bundle for the snooping Wishbone arbiter: core ports, memory slave port and snoop broadcast.
// Handshake: a core beat is pending while cyc&stb are high and is closed by exactly one cycle of
// ack/err/rty; a snoop request is a level held until its completion cycle, and a core may only
// assert snoop_ack (with snoop_hit/snoop_dat valid) while its snoop_req bit is high.
interface wb_snoop_coherence_arbiter_if #(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int num_cores = 2
);
  logic [num_cores*aw-1:0] wbm_adr_i;
  logic [num_cores*dw-1:0] wbm_dat_i;
  logic [num_cores*4-1:0]  wbm_sel_i;
  logic [num_cores-1:0]    wbm_we_i;
  logic [num_cores-1:0]    wbm_cyc_i;
  logic [num_cores-1:0]    wbm_stb_i;
  logic [num_cores*3-1:0]  wbm_cti_i;
  logic [num_cores*2-1:0]  wbm_bte_i;
  logic [num_cores*dw-1:0] wbm_dat_o;
  logic [num_cores-1:0]    wbm_ack_o;
  logic [num_cores-1:0]    wbm_err_o;
  logic [num_cores-1:0]    wbm_rty_o;

  logic [aw-1:0]           wbs_adr_o;
  logic [dw-1:0]           wbs_dat_o;
  logic [3:0]              wbs_sel_o;
  logic                    wbs_we_o;
  logic [2:0]              wbs_cti_o;
  logic [1:0]              wbs_bte_o;
  logic                    wbs_cyc_o;
  logic                    wbs_stb_o;
  logic [dw-1:0]           wbs_dat_i;
  logic                    wbs_ack_i;
  logic                    wbs_err_i;
  logic                    wbs_rty_i;

  logic [num_cores-1:0]    snoop_req_o;
  logic [1:0]              snoop_type_o;
  logic [aw-1:0]           snoop_adr_o;
  logic [num_cores-1:0]    snoop_ack_i;
  logic [num_cores-1:0]    snoop_hit_i;
  logic [num_cores*dw-1:0] snoop_dat_i;
  logic                    snoop_timeout_o;

  // Arbiter view.
  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output snoop_req_o, snoop_type_o, snoop_adr_o, snoop_timeout_o,
    input  snoop_ack_i, snoop_hit_i, snoop_dat_i
  );

  // Environment view: cores, memory and snoop responders.
  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  snoop_req_o, snoop_type_o, snoop_adr_o, snoop_timeout_o,
    output snoop_ack_i, snoop_hit_i, snoop_dat_i
  );
endinterface

// File: rtl/wb_snoop_coherence_arbiter.sv
// Round-robin N-to-1 Wishbone arbiter that snoops every other core before each granted beat and
// either returns a snooped word (read hit) or forwards the beat to the shared memory slave.
module wb_snoop_coherence_arbiter #(
  parameter int dw            = 32,
  parameter int aw            = 32,
  parameter int num_cores     = 2,
  parameter int snoop_timeout = 15
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  wb_snoop_coherence_arbiter_if.slave bus,
  output logic [1:0]                  state_o
);
  localparam int IW = (num_cores > 1) ? $clog2(num_cores) : 1;
  localparam int CW = $clog2(snoop_timeout + 1);

  typedef enum logic [1:0] {IDLE, SNOOP, HIT_ACK, MEM} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d, last_q, last_d;
  logic [aw-1:0]        adr_q, adr_d;
  logic                 we_q, we_d;
  logic [num_cores-1:0] ack_seen_q, ack_seen_d;
  logic                 hit_seen_q, hit_seen_d;
  logic [dw-1:0]        hit_dat_q, hit_dat_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 hold_q, hold_d;

  logic [num_cores-1:0] req_vec, grant_oh, snoop_req, ack_now, hit_now;
  logic [IW-1:0]        pick, cand, beat_idx;
  logic                 found, start, g_cyc, g_stb, snoop_full, snoop_to, slave_done;
  logic                 timeout_pulse;

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    req_vec = bus.wbm_cyc_i & bus.wbm_stb_i;
    found   = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int i = 0; i < num_cores; i++) begin
      cand = IW'((int'(last_q) + 1 + i) % num_cores);
      if (!found && req_vec[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    grant_oh           = '0;
    grant_oh[grant_q]  = 1'b1;
    g_cyc      = bus.wbm_cyc_i[grant_q];
    g_stb      = bus.wbm_stb_i[grant_q];
    snoop_req  = (state_q == SNOOP) ? ~grant_oh : '0;
    ack_now    = ack_seen_q | (bus.snoop_ack_i & snoop_req);
    hit_now    = bus.snoop_ack_i & bus.snoop_hit_i & snoop_req;
    snoop_full = (ack_now == snoop_req);
    snoop_to   = (cnt_q == CW'(snoop_timeout));
    slave_done = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    adr_d         = adr_q;
    we_d          = we_q;
    ack_seen_d    = ack_seen_q;
    hit_seen_d    = hit_seen_q;
    hit_dat_d     = hit_dat_q;
    cnt_d         = cnt_q;
    hold_d        = 1'b0;
    start         = 1'b0;
    beat_idx      = '0;
    timeout_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        // A master whose beat just ended keeps the grant if it presents another beat.
        if (hold_q && g_cyc && g_stb) begin
          start    = 1'b1;
          beat_idx = grant_q;
        end else if (found) begin
          start    = 1'b1;
          beat_idx = pick;
          grant_d  = pick;
          last_d   = pick;
        end
        if (start) begin
          adr_d      = bus.wbm_adr_i[beat_idx*aw +: aw];
          we_d       = bus.wbm_we_i[beat_idx];
          ack_seen_d = '0;
          hit_seen_d = 1'b0;
          hit_dat_d  = '0;
          cnt_d      = CW'(1);
          state_d    = (num_cores == 1) ? MEM : SNOOP;
        end
      end
      SNOOP: begin
        if (!g_cyc) begin
          state_d = IDLE;
        end else begin
          ack_seen_d = ack_now;
          if (!hit_seen_q && (hit_now != '0)) begin
            hit_seen_d = 1'b1;
            for (int i = num_cores - 1; i >= 0; i--) begin
              if (hit_now[i]) hit_dat_d = bus.snoop_dat_i[i*dw +: dw];
            end
          end
          if (snoop_full || snoop_to) begin
            timeout_pulse = !snoop_full;
            state_d = (!we_q && (hit_seen_q || (hit_now != '0))) ? HIT_ACK : MEM;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HIT_ACK: begin
        state_d = IDLE;
        hold_d  = 1'b1;
      end
      MEM: begin
        if (slave_done) begin
          state_d = IDLE;
          hold_d  = 1'b1;
        end else if (!g_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(num_cores - 1);
      adr_q      <= '0;
      we_q       <= 1'b0;
      ack_seen_q <= '0;
      hit_seen_q <= 1'b0;
      hit_dat_q  <= '0;
      cnt_q      <= '0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      adr_q      <= adr_d;
      we_q       <= we_d;
      ack_seen_q <= ack_seen_d;
      hit_seen_q <= hit_seen_d;
      hit_dat_q  <= hit_dat_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
    end
  end

  logic [num_cores-1:0] ack_v, err_v, rty_v;
  logic [dw-1:0]        rdat_v;

  always_comb begin
    ack_v  = '0;
    err_v  = '0;
    rty_v  = '0;
    rdat_v = '0;
    if (state_q == HIT_ACK) begin
      ack_v[grant_q] = 1'b1;
      rdat_v         = hit_dat_q;
    end else if (state_q == MEM) begin
      ack_v[grant_q] = bus.wbs_ack_i;
      err_v[grant_q] = bus.wbs_err_i;
      rty_v[grant_q] = bus.wbs_rty_i;
      rdat_v         = bus.wbs_dat_i;
    end
  end

  assign bus.wbm_ack_o       = ack_v;
  assign bus.wbm_err_o       = err_v;
  assign bus.wbm_rty_o       = rty_v;
  assign bus.wbm_dat_o       = {num_cores{rdat_v}};
  assign bus.wbs_cyc_o       = (state_q == MEM);
  assign bus.wbs_stb_o       = (state_q == MEM) && g_stb;
  assign bus.wbs_adr_o       = (state_q == MEM) ? adr_q : '0;
  assign bus.wbs_we_o        = (state_q == MEM) && we_q;
  assign bus.wbs_dat_o       = (state_q == MEM) ? bus.wbm_dat_i[grant_q*dw +: dw] : '0;
  assign bus.wbs_sel_o       = (state_q == MEM) ? bus.wbm_sel_i[grant_q*4 +: 4] : '0;
  assign bus.wbs_cti_o       = (state_q == MEM) ? bus.wbm_cti_i[grant_q*3 +: 3] : '0;
  assign bus.wbs_bte_o       = (state_q == MEM) ? bus.wbm_bte_i[grant_q*2 +: 2] : '0;
  assign bus.snoop_req_o     = snoop_req;
  assign bus.snoop_type_o    = (state_q == SNOOP) ? (we_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.snoop_adr_o     = (state_q == SNOOP) ? adr_q : '0;
  assign bus.snoop_timeout_o = timeout_pulse;
  assign state_o             = state_q;
endmodule

// File: tb/tb_wb_snoop_coherence_arbiter.sv
// Bench for the snooping arbiter: a two-core instance for the main flows and a four-core
// instance for the snoop timeout; expected read data flows through a scoreboard queue.
module tb_wb_snoop_coherence_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_snoop_coherence_arbiter_if #(.dw(32), .aw(32), .num_cores(2)) b2 ();
  wb_snoop_coherence_arbiter_if #(.dw(32), .aw(32), .num_cores(4)) b4 ();
  logic [1:0] st2, st4;

  wb_snoop_coherence_arbiter #(.dw(32), .aw(32), .num_cores(2), .snoop_timeout(15)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(b2.slave), .state_o(st2));
  wb_snoop_coherence_arbiter #(.dw(32), .aw(32), .num_cores(4), .snoop_timeout(15)) dut4 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .bus(b4.slave), .state_o(st4));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  int          r_lat, r_snp;
  bit          r_mem;
  logic [1:0]  r_type;
  logic [31:0] r_sadr, r_wadr, r_wdat;
  logic        r_wwe;

  task automatic init_inputs();
    b2.wbm_adr_i = '0; b2.wbm_dat_i = '0; b2.wbm_sel_i = '0; b2.wbm_we_i = '0;
    b2.wbm_cyc_i = '0; b2.wbm_stb_i = '0; b2.wbm_cti_i = '0; b2.wbm_bte_i = '0;
    b2.wbs_dat_i = '0; b2.wbs_ack_i = 1'b0; b2.wbs_err_i = 1'b0; b2.wbs_rty_i = 1'b0;
    b2.snoop_ack_i = '0; b2.snoop_hit_i = '0; b2.snoop_dat_i = '0;
    b4.wbm_adr_i = '0; b4.wbm_dat_i = '0; b4.wbm_sel_i = '0; b4.wbm_we_i = '0;
    b4.wbm_cyc_i = '0; b4.wbm_stb_i = '0; b4.wbm_cti_i = '0; b4.wbm_bte_i = '0;
    b4.wbs_dat_i = '0; b4.wbs_ack_i = 1'b0; b4.wbs_err_i = 1'b0; b4.wbs_rty_i = 1'b0;
    b4.snoop_ack_i = '0; b4.snoop_hit_i = '0; b4.snoop_dat_i = '0;
  endtask

  task automatic set_req(input int m, input logic on, input logic we, input logic [31:0] adr,
                         input logic [31:0] wdat);
    b2.wbm_cyc_i[m]         = on;
    b2.wbm_stb_i[m]         = on;
    b2.wbm_we_i[m]          = we;
    b2.wbm_adr_i[m*32 +: 32] = adr;
    b2.wbm_dat_i[m*32 +: 32] = wdat;
    b2.wbm_sel_i[m*4 +: 4]   = on ? 4'hF : 4'h0;
  endtask

  // Drives one beat from core m (called just after a rising edge) and acts as snoop responders
  // and as a memory slave that acks on its second MEM cycle.
  task automatic do_beat(input int m, input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [1:0] ack_mask, input logic [1:0] hit_mask,
                         input logic [31:0] hit_word, input logic [31:0] mem_word, input bit last);
    logic [1:0]  oh;
    logic [31:0] exp;
    int          mcnt;
    bit          done;
    oh  = 2'b01 << m;
    exp = (!we && ((hit_mask & ack_mask & ~oh) != 2'b00)) ? hit_word : mem_word;
    exp_q.push_back(exp);
    set_req(m, 1'b1, we, adr, wdat);
    r_lat = 0; r_snp = 0; r_mem = 0; r_type = 2'b00; r_sadr = '0;
    r_wadr = '0; r_wdat = '0; r_wwe = 1'b0;
    done = 0; mcnt = 0;
    while (!done && r_lat < 60) begin
      @(negedge clk);
      r_lat++;
      b2.snoop_ack_i = b2.snoop_req_o & ack_mask;
      b2.snoop_hit_i = b2.snoop_req_o & hit_mask;
      b2.snoop_dat_i = {2{hit_word}};
      if (b2.wbs_cyc_o && b2.wbs_stb_o) begin
        mcnt++;
        if (mcnt == 2) begin
          b2.wbs_ack_i = 1'b1;
          b2.wbs_dat_i = mem_word;
        end
      end
      #1;
      if (b2.snoop_req_o != 2'b00) begin
        r_snp++;
        r_type = b2.snoop_type_o;
        r_sadr = b2.snoop_adr_o;
      end
      if (b2.wbs_cyc_o) begin
        r_mem  = 1;
        r_wadr = b2.wbs_adr_o;
        r_wdat = b2.wbs_dat_o;
        r_wwe  = b2.wbs_we_o;
      end
      if (b2.wbm_ack_o != 2'b00) begin
        done = 1;
        checks++;
        if (b2.wbm_ack_o !== oh) begin
          failures++;
          $display("FAIL ack_onehot got=%b exp=%b", b2.wbm_ack_o, oh);
        end
        checks++;
        if ((b2.wbm_err_o | b2.wbm_rty_o) !== 2'b00) begin
          failures++;
          $display("FAIL err_rty got=%b/%b exp=00/00", b2.wbm_err_o, b2.wbm_rty_o);
        end
        exp = exp_q.pop_front();
        checks++;
        if (b2.wbm_dat_o !== {exp, exp}) begin
          failures++;
          $display("FAIL read_data got=%h exp=%h", b2.wbm_dat_o, {exp, exp});
        end
      end
      @(posedge clk); #1;
      b2.snoop_ack_i = '0;
      b2.snoop_hit_i = '0;
      b2.wbs_ack_i   = 1'b0;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL beat_timeout core=%0d got=no_ack exp=ack", m);
      exp_q.delete();
    end
    if (last) set_req(m, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    init_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (st2 !== 2'b00 || b2.wbs_cyc_o !== 1'b0 || b2.wbm_ack_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_outputs got=st%b cyc%b ack%b exp=st00 cyc0 ack00", st2, b2.wbs_cyc_o, b2.wbm_ack_o);
    end
    checks++;
    if (b2.snoop_req_o !== 2'b00 || b2.snoop_type_o !== 2'b00 || b2.snoop_timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_snoop got=req%b type%b to%b exp=00/00/0", b2.snoop_req_o, b2.snoop_type_o, b2.snoop_timeout_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    set_req(0, 1'b1, 1'b0, 32'h10, '0);
    set_req(1, 1'b1, 1'b0, 32'h20, '0);
    for (int k = 0; k < 5; k++) begin
      int m;
      m = k % 2;
      do_beat(m, 1'b0, 32'h10 + 32'(m) * 32'h10, '0, 2'b11, 2'b00, '0, 32'hA0 + 32'(k), 1);
      @(posedge clk); #1;
      if (k < 3) set_req(m, 1'b1, 1'b0, 32'h10 + 32'(m) * 32'h10, '0);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_read_hit();
    do_beat(0, 1'b0, 32'h100, '0, 2'b10, 2'b10, 32'hDEADBEEF, 32'h0BAD0BAD, 1);
    checks++;
    if (r_lat !== 3) begin failures++; $display("FAIL hit_latency got=%0d exp=3", r_lat); end
    checks++;
    if (r_mem !== 1'b0) begin failures++; $display("FAIL hit_no_mem got=%0d exp=0", r_mem); end
    checks++;
    if (r_snp !== 1 || r_type !== 2'b01 || r_sadr !== 32'h100) begin
      failures++;
      $display("FAIL hit_snoop got=%0d/%b/%h exp=1/01/00000100", r_snp, r_type, r_sadr);
    end
  endtask

  task automatic test_write_invalidate();
    do_beat(1, 1'b1, 32'h200, 32'h55AA55AA, 2'b01, 2'b00, '0, 32'h12345678, 1);
    checks++;
    if (r_lat !== 4) begin failures++; $display("FAIL wr_latency got=%0d exp=4", r_lat); end
    checks++;
    if (r_snp !== 1 || r_type !== 2'b10 || r_sadr !== 32'h200) begin
      failures++;
      $display("FAIL wr_snoop got=%0d/%b/%h exp=1/10/00000200", r_snp, r_type, r_sadr);
    end
    checks++;
    if (r_mem !== 1'b1 || r_wadr !== 32'h200 || r_wwe !== 1'b1 || r_wdat !== 32'h55AA55AA) begin
      failures++;
      $display("FAIL wr_slave got=%0d/%h/%b/%h exp=1/00000200/1/55aa55aa", r_mem, r_wadr, r_wwe, r_wdat);
    end
    // A hit answered to an invalidate must not short-circuit the write.
    do_beat(0, 1'b1, 32'h204, 32'h0000BEEF, 2'b10, 2'b10, 32'hFFFF0000, 32'h0000AAAA, 1);
    checks++;
    if (r_mem !== 1'b1 || r_wadr !== 32'h204) begin
      failures++;
      $display("FAIL wr_hit_ignored got=%0d/%h exp=1/00000204", r_mem, r_wadr);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      do_beat(0, 1'b0, 32'(i * 4), '0, 2'b11, 2'b00, '0, 32'hB000 + 32'(i), i == 3);
      checks++;
      if (r_snp !== 1 || r_sadr !== 32'(i * 4) || r_wadr !== 32'(i * 4)) begin
        failures++;
        $display("FAIL burst_beat%0d got=%0d/%h/%h exp=1/%h/%h", i, r_snp, r_sadr, r_wadr, i * 4, i * 4);
      end
      if (i == 0) set_req(1, 1'b1, 1'b0, 32'h900, '0);
    end
    do_beat(1, 1'b0, 32'h900, '0, 2'b11, 2'b00, '0, 32'hC0C0C0C0, 1);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mem();
    bit reached;
    reached = 0;
    set_req(0, 1'b1, 1'b1, 32'h500, 32'h77);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      b2.snoop_ack_i = b2.snoop_req_o & 2'b10;
      #1;
      if (b2.wbs_cyc_o) begin
        reached = 1;
        break;
      end
      @(posedge clk); #1;
      b2.snoop_ack_i = '0;
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL mid_mem_reach got=0 exp=1"); end
    b2.wbs_ack_i = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b2.wbs_cyc_o !== 1'b0 || b2.wbs_stb_o !== 1'b0 || b2.wbm_ack_o !== 2'b00 || st2 !== 2'b00) begin
      failures++;
      $display("FAIL async_reset got=cyc%b stb%b ack%b st%b exp=0/0/00/00", b2.wbs_cyc_o, b2.wbs_stb_o, b2.wbm_ack_o, st2);
    end
    checks++;
    if (b2.snoop_req_o !== 2'b00 || b2.wbs_adr_o !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_bus got=req%b adr%h exp=00/00000000", b2.snoop_req_o, b2.wbs_adr_o);
    end
    b2.wbs_ack_i = 1'b0;
    b2.snoop_ack_i = '0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_beat(0, 1'b0, 32'h600, '0, 2'b10, 2'b10, 32'h600D600D, 32'h0, 1);
    checks++;
    if (r_lat !== 3) begin failures++; $display("FAIL post_reset_latency got=%0d exp=3", r_lat); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int snp, pulses, pulse_at;
    bit mem, done;
    logic [31:0] exp;
    snp = 0; pulses = 0; pulse_at = 0; mem = 0; done = 0;
    b4.wbm_cyc_i[0] = 1'b1;
    b4.wbm_stb_i[0] = 1'b1;
    b4.wbm_we_i[0]  = 1'b0;
    b4.wbm_adr_i[31:0] = 32'h300;
    exp_q.push_back(32'hCAFE0004);
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      b4.snoop_ack_i = b4.snoop_req_o & 4'b1010;
      if (b4.wbs_cyc_o && b4.wbs_stb_o) begin
        b4.wbs_ack_i = 1'b1;
        b4.wbs_dat_i = 32'hCAFE0004;
      end
      #1;
      if (b4.snoop_req_o != 4'b0000) snp++;
      if (b4.snoop_timeout_o) begin pulses++; pulse_at = snp; end
      if (b4.wbs_cyc_o) mem = 1;
      if (b4.wbm_ack_o != 4'b0000) begin
        done = 1;
        exp = exp_q.pop_front();
        checks++;
        if (b4.wbm_ack_o !== 4'b0001 || b4.wbm_dat_o !== {4{exp}}) begin
          failures++;
          $display("FAIL to_ack got=%b/%h exp=0001/%h", b4.wbm_ack_o, b4.wbm_dat_o[31:0], exp);
        end
      end
      @(posedge clk); #1;
      b4.snoop_ack_i = '0;
      b4.wbs_ack_i   = 1'b0;
    end
    b4.wbm_cyc_i = '0;
    b4.wbm_stb_i = '0;
    checks++;
    if (!done) begin failures++; $display("FAIL to_done got=no_ack exp=ack"); exp_q.delete(); end
    checks++;
    if (snp !== 15 || pulses !== 1 || pulse_at !== 15) begin
      failures++;
      $display("FAIL to_pulse got=snp%0d pulses%0d at%0d exp=15/1/15", snp, pulses, pulse_at);
    end
    checks++;
    if (mem !== 1'b1) begin failures++; $display("FAIL to_miss_mem got=%0d exp=1", mem); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read_hit();
    test_write_invalidate();
    test_back_to_back();
    test_reset_mid_mem();
    test_timeout();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
